// File: rtl/counter_mod.sv
// -----------------------------------------------------------------------------
// counter_mod -- parametrised up/down modulo counter
//
// Purpose:
//   Counts from 0 to MAX_VAL, up or down. At either bound it wraps or
//   saturates. It also supports a synchronous clear, a synchronous load with
//   clamping, a registered terminal-count pulse and a sticky overflow flag.
//   Each timing channel of the Morse timing logic uses one instance, for
//   dot/dash/gap lengths and for decade digit counting.
//
// Optional build macro:
//   COUNTER_MOD_PRESCALE_EN -- when defined, an internal prescaler divides
//   the ce strobes by PRESC. When undefined, every ce=1 cycle is a count step
//   and PRESC is only range-checked.
//
// Parameters:
//   W        counter width in bits
//   MAX_VAL  last count value before wrap (1 .. 2**W-1)
//   SCLR_VAL value taken on reset and on sclr (0 .. MAX_VAL)
//   PRESC    ce prescale ratio (>= 1)
//
// Ports:
//   clk      in   clock, rising edge
//   nrst     in   asynchronous active-low reset
//   sclr     in   synchronous clear (highest priority, ignores ce)
//   ce       in   count enable
//   load     in   synchronous load of ld_val (does not need ce)
//   ld_val   in   load value, clamped to MAX_VAL
//   dir      in   1 = up, 0 = down
//   sat      in   1 = saturate at bounds, 0 = wrap
//   ovf_clr  in   clears the sticky ovf flag (a coincident event wins)
//   cnt      out  registered counter value
//   tc       out  registered one-cycle terminal-count pulse
//   ovf      out  registered sticky boundary-event flag
//   is_max   out  combinational cnt == MAX_VAL
//   is_zero  out  combinational cnt == 0
// -----------------------------------------------------------------------------
module counter_mod #(
  parameter int W        = 4,
  parameter int MAX_VAL  = 2**W - 1,
  parameter int SCLR_VAL = 0,
  parameter int PRESC    = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         sclr,
  input  logic         ce,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         dir,
  input  logic         sat,
  input  logic         ovf_clr,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         ovf,
  output logic         is_max,
  output logic         is_zero
);

  // Elaboration-time parameter checks. An out-of-range count is reachable
  // only through a bad parameter set, so the build is refused instead.
  if (W < 1) begin : g_bad_w
    $error("counter_mod: W must be >= 1");
  end
  if ((MAX_VAL < 1) || (MAX_VAL > (2**W) - 1)) begin : g_bad_max
    $error("counter_mod: MAX_VAL must lie in 1 .. 2**W-1");
  end
  if ((SCLR_VAL < 0) || (SCLR_VAL > MAX_VAL)) begin : g_bad_sclr
    $error("counter_mod: SCLR_VAL must lie in 0 .. MAX_VAL");
  end
  if (PRESC < 1) begin : g_bad_presc
    $error("counter_mod: PRESC must be >= 1");
  end

  localparam logic [W-1:0] MAX_W  = W'(MAX_VAL);
  localparam logic [W-1:0] SCLR_W = W'(SCLR_VAL);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] ld_clamped;
  logic         step;

  // Loads above the modulus would produce a count outside the legal range.
  assign ld_clamped = (ld_val > MAX_W) ? MAX_W : ld_val;

`ifdef COUNTER_MOD_PRESCALE_EN
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_q, presc_d;

  // The count step happens on the ce cycle that completes a prescale period.
  assign step = ce && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (sclr || load) begin
      presc_d = '0;
    end else if (ce) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step = ce;
`endif

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (sclr) begin
      cnt_d = SCLR_W;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = ld_clamped;
      if (ovf_clr) begin
        ovf_d = 1'b0;
      end
    end else begin
      // The clear is applied first, so a boundary event on the same edge
      // sets the flag again and wins.
      if (ovf_clr) begin
        ovf_d = 1'b0;
      end
      if (step) begin
        if (dir) begin
          if (cnt_q == MAX_W) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            cnt_d = sat ? MAX_W : '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            cnt_d = sat ? '0 : MAX_W;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= SCLR_W;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt     = cnt_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign is_max  = (cnt_q == MAX_W);
  assign is_zero = (cnt_q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_mod -- directed self-checking bench for counter_mod
// (W=4, MAX_VAL=9, SCLR_VAL=0). When COUNTER_MOD_PRESCALE_EN is defined,
// a second instance with PRESC=3 is driven by the same inputs.
// -----------------------------------------------------------------------------
module tb_counter_mod;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         nrst, sclr, ce, load, dir, sat, ovf_clr;
  logic [W-1:0] ld_val;
  logic [W-1:0] cnt;
  logic         tc, ovf, is_max, is_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  counter_mod #(.W(W), .MAX_VAL(9), .SCLR_VAL(0), .PRESC(1)) u_dut (
    .clk(clk), .nrst(nrst), .sclr(sclr), .ce(ce), .load(load),
    .ld_val(ld_val), .dir(dir), .sat(sat), .ovf_clr(ovf_clr),
    .cnt(cnt), .tc(tc), .ovf(ovf), .is_max(is_max), .is_zero(is_zero)
  );

`ifdef COUNTER_MOD_PRESCALE_EN
  logic [W-1:0] cnt_p;
  logic         tc_p, ovf_p, is_max_p, is_zero_p;

  counter_mod #(.W(W), .MAX_VAL(9), .SCLR_VAL(0), .PRESC(3)) u_dut_p (
    .clk(clk), .nrst(nrst), .sclr(sclr), .ce(ce), .load(load),
    .ld_val(ld_val), .dir(dir), .sat(sat), .ovf_clr(ovf_clr),
    .cnt(cnt_p), .tc(tc_p), .ovf(ovf_p), .is_max(is_max_p), .is_zero(is_zero_p)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
      $display("[%0t] ok   %s = %0d", $time, tag, obs);
    end else begin
      $display("[%0t] FAIL %s: got %0d, expected %0d", $time, tag, obs, exp_v);
    end
  endtask

  // One clock edge, then settle 1 time unit past it before any sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; sclr = 1'b0; ce = 1'b0; load = 1'b0; ld_val = '0;
    dir = 1'b1; sat = 1'b0; ovf_clr = 1'b0;

    // Reset state
    #12;
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_tc", tc, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_is_zero", is_zero, 1);
    nrst = 1'b1;

    // Up count with wrap: 1..9, 0, 1
    ce = 1'b1; dir = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      check_eq($sformatf("up_cnt%0d", i), cnt, i % 10);
      check_eq($sformatf("up_tc%0d", i), tc, (i == 10) ? 1 : 0);
      check_eq($sformatf("up_ovf%0d", i), ovf, (i >= 10) ? 1 : 0);
      check_eq($sformatf("up_ismax%0d", i), is_max, (i == 9) ? 1 : 0);
    end

    // Clear ovf while idle, then load 2
    ce = 1'b0; ovf_clr = 1'b1;
    step();
    check_eq("clr_ovf", ovf, 0);
    check_eq("clr_cnt_hold", cnt, 1);
    check_eq("clr_tc", tc, 0);
    ovf_clr = 1'b0; load = 1'b1; ld_val = 4'd2;
    step();
    check_eq("ld2_cnt", cnt, 2);
    load = 1'b0;

    // Down, saturate: 1, 0, 0(hold), 0(hold)
    ce = 1'b1; dir = 1'b0; sat = 1'b1;
    step();
    check_eq("dn_cnt1", cnt, 1);
    check_eq("dn_tc1", tc, 0);
    step();
    check_eq("dn_cnt0", cnt, 0);
    check_eq("dn_tc0", tc, 0);
    check_eq("dn_ovf0", ovf, 0);
    check_eq("dn_is_zero", is_zero, 1);
    step();
    check_eq("hold1_cnt", cnt, 0);
    check_eq("hold1_tc", tc, 1);
    check_eq("hold1_ovf", ovf, 1);
    step();
    check_eq("hold2_tc", tc, 1);
    ovf_clr = 1'b1;
    step();
    check_eq("hold3_cnt", cnt, 0);
    check_eq("hold3_tc", tc, 1);
    check_eq("hold3_ovf_set_wins", ovf, 1);
    ovf_clr = 1'b0; ce = 1'b0;
    step();
    check_eq("idle_tc", tc, 0);
    check_eq("idle_ovf", ovf, 1);

    // Down, wrap: 0 -> 9
    ce = 1'b1; sat = 1'b0;
    step();
    check_eq("dnwrap_cnt", cnt, 9);
    check_eq("dnwrap_tc", tc, 1);

    // Load clamp beats count; sclr beats load
    dir = 1'b1; load = 1'b1; ld_val = 4'd13;
    step();
    check_eq("ldclamp_cnt", cnt, 9);
    check_eq("ldclamp_tc", tc, 0);
    check_eq("ldclamp_ovf", ovf, 1);
    sclr = 1'b1; ld_val = 4'd5;
    step();
    check_eq("sclr_cnt", cnt, 0);
    check_eq("sclr_ovf", ovf, 0);
    check_eq("sclr_tc", tc, 0);
    sclr = 1'b0;

    // Async reset mid-count at cnt=7 with ovf set
    ld_val = 4'd9;
    step();                       // load 9
    load = 1'b0;
    step();                       // 9 -> 0, event
    check_eq("pre_ovf", ovf, 1);
    load = 1'b1; ld_val = 4'd6;
    step();
    load = 1'b0;
    step();
    check_eq("pre_rst_cnt", cnt, 7);
    #1 nrst = 1'b0;
    #1;
    check_eq("arst_cnt", cnt, 0);
    check_eq("arst_tc", tc, 0);
    check_eq("arst_ovf", ovf, 0);
    #1 nrst = 1'b1;
    step();
    check_eq("resume_cnt", cnt, 1);

    // ce toggling 1,0,1,0
    step();
    check_eq("tog1_cnt", cnt, 2);
    ce = 1'b0;
    step();
    check_eq("tog2_cnt", cnt, 2);
    check_eq("tog2_tc", tc, 0);
    ce = 1'b1;
    step();
    check_eq("tog3_cnt", cnt, 3);
    ce = 1'b0;
    step();
    check_eq("tog4_cnt", cnt, 3);
    check_eq("tog4_tc", tc, 0);

`ifdef COUNTER_MOD_PRESCALE_EN
    // Prescale by 3, then a load mid-period restarts the period
    sclr = 1'b1;
    step();
    sclr = 1'b0; ce = 1'b1; dir = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_eq($sformatf("psc_cnt%0d", i), cnt_p, i / 3);
    end
    load = 1'b1; ld_val = 4'd5;
    step();
    check_eq("psc_ld_cnt", cnt_p, 5);
    load = 1'b0;
    step();
    check_eq("psc_r1_cnt", cnt_p, 5);
    step();
    check_eq("psc_r2_cnt", cnt_p, 5);
    step();
    check_eq("psc_r3_cnt", cnt_p, 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
